// File: rtl/fp_mult_issue_if.sv
// Handshake and decoded-operand bundle between the operand source, the issue
// buffer and the multiplier stage.
interface fp_mult_issue_if #(
    parameter int DEPTH = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            operand_a;
    logic [31:0]            operand_b;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sign_p;
    logic signed [9:0]      exp_sum;
    logic [23:0]            mant_a;
    logic [23:0]            mant_b;
    logic                   special;
    logic [31:0]            special_result;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output in_valid, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, sign_p, exp_sum, mant_a, mant_b,
               special, special_result, count
    );

    modport slave (
        input  in_valid, operand_a, operand_b, out_ready,
        output in_ready, out_valid, sign_p, exp_sum, mant_a, mant_b,
               special, special_result, count
    );
endinterface

// File: rtl/fp_mult_issue.sv
// Operand issue buffer for a single-precision multiplier: decodes and classifies
// each operand pair on entry and queues it in a small circular FIFO.
module fp_mult_issue #(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_mult_issue_if.slave bus
);
    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] QNAN  = 32'h7fc00000;

    typedef struct packed {
        logic              sign_p;
        logic signed [9:0] exp_sum;
        logic [23:0]       mant_a;
        logic [23:0]       mant_b;
        logic              special;
        logic [31:0]       special_result;
    } entry_t;

    // Denormals flush to zero, so an all-zero exponent field drops the hidden bit too.
    function automatic logic [23:0] mant_ftz(input logic [31:0] x);
        return (x[30:23] == 8'h00) ? 24'h000000 : {1'b1, x[22:0]};
    endfunction

    // Wraps freely in 10 bits; range handling belongs to the normalise stage.
    function automatic logic signed [9:0] exp_add(input logic [7:0] ea, input logic [7:0] eb);
        logic signed [9:0] sa;
        logic signed [9:0] sb;
        sa = signed'({2'b00, ea});
        sb = signed'({2'b00, eb});
        return sa + sb - 10'sd127;
    endfunction

    function automatic entry_t decode(input logic [31:0] a, input logic [31:0] b);
        entry_t e;
        logic   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'h0);
        b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'h0);
        a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'h0);
        b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'h0);

        e.sign_p  = a[31] ^ b[31];
        e.exp_sum = exp_add(a[30:23], b[30:23]);
        e.mant_a  = mant_ftz(a);
        e.mant_b  = mant_ftz(b);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            e.special        = 1'b1;
            e.special_result = QNAN;
        end else if (a_inf || b_inf) begin
            e.special        = 1'b1;
            e.special_result = {e.sign_p, 8'hff, 23'h0};
        end else if (a_zero || b_zero) begin
            e.special        = 1'b1;
            e.special_result = {e.sign_p, 31'h0};
        end else begin
            e.special        = 1'b0;
            e.special_result = 32'h00000000;
        end
        return e;
    endfunction

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    logic             vld_p1;
    entry_t           entry_p0;
    entry_t           head_p1;
    entry_t           fifo_p1 [DEPTH];

    // Stage 0: decode incoming pair
    assign entry_p0     = decode(bus.operand_a, bus.operand_b);
    assign bus.in_ready = (count_q < CNT_W'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = vld_p1 && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_p1[wr_ptr] <= entry_p0;
    end

    // Stage 1: head entry presented; data masked to zero whenever nothing is queued
    assign vld_p1             = (count_q != '0);
    assign head_p1            = fifo_p1[rd_ptr];
    assign bus.out_valid      = vld_p1;
    assign bus.count          = count_q;
    assign bus.sign_p         = vld_p1 ? head_p1.sign_p         : 1'b0;
    assign bus.exp_sum        = vld_p1 ? head_p1.exp_sum        : 10'sd0;
    assign bus.mant_a         = vld_p1 ? head_p1.mant_a         : 24'h0;
    assign bus.mant_b         = vld_p1 ? head_p1.mant_b         : 24'h0;
    assign bus.special        = vld_p1 ? head_p1.special        : 1'b0;
    assign bus.special_result = vld_p1 ? head_p1.special_result : 32'h0;
endmodule

// File: tb/tb_fp_mult_issue.sv
// Directed scoreboard bench for fp_mult_issue.
module tb_fp_mult_issue;
    localparam int DEPTH = 2;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [23:0] ma;
        logic [23:0] mb;
        logic        sp;
        logic [31:0] sr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    fp_mult_issue_if #(.DEPTH(DEPTH)) bus ();

    fp_mult_issue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        int   ea;
        int   eb;
        bit   za, zb, ia, ib, na, nb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'h0);
        ib = (eb == 255) && (b[22:0] == 23'h0);
        na = (ea == 255) && (a[22:0] != 23'h0);
        nb = (eb == 255) && (b[22:0] != 23'h0);
        r.s  = a[31] ^ b[31];
        r.e  = 10'(ea + eb - 127);
        r.ma = za ? 24'h0 : {1'b1, a[22:0]};
        r.mb = zb ? 24'h0 : {1'b1, b[22:0]};
        r.sp = 1'b1;
        if (na || nb || (ia && zb) || (ib && za))
            r.sr = 32'h7fc00000;
        else if (ia || ib)
            r.sr = r.s ? 32'hff800000 : 32'h7f800000;
        else if (za || zb)
            r.sr = r.s ? 32'h80000000 : 32'h00000000;
        else begin
            r.sp = 1'b0;
            r.sr = 32'h00000000;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid  = v;
        bus.operand_a = a;
        bus.operand_b = b;
    endtask

    // One clock: compare at the falling edge, update the model for the coming rising edge.
    task automatic step();
        exp_t h;
        bit   ready_m;
        @(negedge clk);
        ready_m = (sb.size() < DEPTH);
        check("count", 32'(bus.count), 32'(sb.size()));
        check("in_ready", 32'(bus.in_ready), 32'(ready_m));
        check("out_valid", 32'(bus.out_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            h = sb[0];
            check("sign_p", 32'(bus.sign_p), 32'(h.s));
            check("exp_sum", 32'({bus.exp_sum}), 32'(h.e));
            check("mant_a", 32'(bus.mant_a), 32'(h.ma));
            check("mant_b", 32'(bus.mant_b), 32'(h.mb));
            check("special", 32'(bus.special), 32'(h.sp));
            check("special_result", bus.special_result, h.sr);
            if (bus.out_ready) void'(sb.pop_front());
        end else begin
            check("idle_data", 32'({bus.sign_p, bus.exp_sum, bus.special}), 32'h0);
            check("idle_mant", 32'(bus.mant_a | bus.mant_b), 32'h0);
            check("idle_result", bus.special_result, 32'h0);
        end
        if (bus.in_valid && ready_m) sb.push_back(model(bus.operand_a, bus.operand_b));
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, a, b);
        step();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'h0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'h1);
        check({tag, "_result"}, bus.special_result, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // First edge after release accepts; output appears only one cycle later.
        bus.out_ready = 1'b1;
        pair(32'h3f800000, 32'h3fc00000);
        check("latency_valid", 32'(bus.out_valid), 32'h1);
        check("latency_exp", 32'({bus.exp_sum}), 32'd127);
        check("latency_mant_b", 32'(bus.mant_b), 32'h00c00000);
        idle(1);

        // Classification corners, streamed back to back
        pair(32'h80000000, 32'h3fc00000);
        pair(32'h80000000, 32'hbfc00000);
        pair(32'h7f800000, 32'h00000000);
        pair(32'hff800000, 32'h40000000);
        pair(32'h00000001, 32'h3f800000);
        pair(32'h7fc00001, 32'h3f800000);
        pair(32'h00000000, 32'hff800000);
        pair(32'h7f7fffff, 32'h7f7fffff);
        pair(32'h00800000, 32'h80800000);
        pair(32'hc0490fdb, 32'h402df854);
        idle(2);

        // Fill while stalled, over-offer, then drain in order
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) pair(32'h3f800000 + 32'(i << 20), 32'h40000000 + 32'(i));
        check("full_in_ready", 32'(bus.in_ready), 32'h0);
        check("full_count", 32'(bus.count), 32'(DEPTH));
        drive(1'b0, 32'h0, 32'h0);
        step();
        bus.out_ready = 1'b1;
        idle(DEPTH + 1);

        // Continuous streaming with pointer wrap
        for (int i = 0; i < 2 * DEPTH + 1; i++) pair($urandom, $urandom);
        idle(2);

        // Reset with pairs buffered
        bus.out_ready = 1'b0;
        pair(32'h40400000, 32'h40800000);
        pair(32'h40a00000, 32'hc0c00000);
        drive(1'b0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        idle(3);
        pair(32'h3fc00000, 32'hbf800000);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
